// File: rtl/fifo_sdp_ctrl.sv
// First-word-fall-through FIFO controller that drives an external simple dual-port RAM.
// The RAM's read register is the output stage, so head data comes straight from the RAM.
module fifo_sdp_ctrl #(
  parameter int unsigned AWIDTH = 9,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DWIDTH-1:0] i_wr_data,
  input  logic              i_wr_ena,
  output logic              o_full,
  output logic [DWIDTH-1:0] o_rd_data,
  input  logic              i_rd_ena,
  output logic              o_empty,
  output logic [AWIDTH:0]   o_level,
  output logic              o_ovf,
  output logic              o_udf,
  output logic [AWIDTH-1:0] o_ram_wr_addr,
  output logic [DWIDTH-1:0] o_ram_wr_data,
  output logic              o_ram_wr_ena,
  output logic [AWIDTH-1:0] o_ram_rd_addr,
  output logic              o_ram_rd_ena,
  input  logic [DWIDTH-1:0] i_ram_rd_data
);

  localparam logic [AWIDTH:0] LP_FULL_CNT = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH-1:0] r_wptr;
  logic [AWIDTH-1:0] r_rptr;
  logic [AWIDTH:0]   r_cnt;
  logic              r_ov;
  logic              r_ovf;
  logic              r_udf;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_fetch;

  assign w_full  = (r_cnt == LP_FULL_CNT);
  assign w_push  = i_wr_ena & ~w_full;
  assign w_pop   = i_rd_ena & r_ov;
  // Refill the output stage whenever it is empty or being consumed this cycle.
  assign w_fetch = (r_cnt != '0) & (~r_ov | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ov   <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AWIDTH'(1);
      end
      if (w_fetch) begin
        r_rptr <= r_rptr + AWIDTH'(1);
      end
      case ({w_push, w_fetch})
        2'b10:   r_cnt <= r_cnt + (AWIDTH + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AWIDTH + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_ov  <= w_fetch | (r_ov & ~w_pop);
      r_ovf <= i_wr_ena & w_full;
      r_udf <= i_rd_ena & ~r_ov;
    end
  end

  assign o_ram_wr_ena  = w_push;
  assign o_ram_wr_addr = r_wptr;
  assign o_ram_wr_data = i_wr_data;
  assign o_ram_rd_ena  = w_fetch;
  assign o_ram_rd_addr = r_rptr;

  assign o_rd_data = i_ram_rd_data;
  assign o_empty   = ~r_ov;
  assign o_full    = w_full;
  assign o_level   = r_cnt + {{AWIDTH{1'b0}}, r_ov};
  assign o_ovf     = r_ovf;
  assign o_udf     = r_udf;

endmodule
